// File: rtl/display_scan_driver_pkg.sv
// Shared definitions for the 2-digit 7-segment scan driver: state encoding,
// digit-select codes and the segment polarity helper.
package display_scan_driver_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DIG_A   = 3'd1,
        ST_BLANK_A = 3'd2,
        ST_DIG_B   = 3'd3,
        ST_BLANK_B = 3'd4
    } scan_state_e;

    localparam logic [1:0] DIG_SEL_A    = 2'b01;
    localparam logic [1:0] DIG_SEL_B    = 2'b10;
    localparam logic [1:0] DIG_SEL_NONE = 2'b00;

    // Map an active-high segment pattern onto the physical bus polarity.
    function automatic logic [6:0] seg_drive(input logic [6:0] pat, input logic active_low);
        logic [6:0] res;
        if (active_low) begin
            res = ~pat;
        end else begin
            res = pat;
        end
        return res;
    endfunction

endpackage

// File: rtl/display_scan_driver_scan_phase_timer.sv
// Phase timer for the scan FSM: counter with synchronous clear and enable.
// term_i is the terminal value of the phase the counter is about to be in,
// so last_o is a registered "this is the final cycle of the phase" flag.
module scan_phase_timer
    import display_scan_driver_pkg::*;
#(
    parameter int pCNT_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_i,
    input  logic                  inc_i,
    input  logic [pCNT_WIDTH-1:0] term_i,
    output logic                  last_o
);

    logic [pCNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                  last_q, last_d;

    // Next count and the look-ahead terminal comparison.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + pCNT_WIDTH'(1);
        end else begin
            cnt_d = cnt_q;
        end
        last_d = (cnt_d == term_i);
    end

    // Counter and last-flag registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            last_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

    assign last_o = last_q;

endmodule

// File: rtl/display_scan_driver.sv
// Two-digit 7-segment scan driver: time-multiplexes seg_a (tens) and seg_b
// (units) onto one segment bus with a one-hot digit select, an all-off gap
// between digits, and a per-phase snapshot so a digit never tears.
// Optional build macro DISPLAY_BLINK_EN adds blink_req and frame-based blinking.
module display_scan_driver
    import display_scan_driver_pkg::*;
#(
    parameter int pSCAN_DIV       = 50,
    parameter int pBLANK_CYC      = 2,
    parameter int pCNT_WIDTH      = 8,
    parameter int pSEG_ACTIVE_LOW = 1
`ifdef DISPLAY_BLINK_EN
    ,
    parameter int pBLINK_FRAMES   = 25
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       lamp_test,
    input  logic [6:0] seg_a,
    input  logic [6:0] seg_b,
`ifdef DISPLAY_BLINK_EN
    input  logic       blink_req,
`endif
    output logic [6:0] seg_out,
    output logic [1:0] dig_sel,
    output logic       frame_done
);

    localparam logic                  ACT_LOW    = (pSEG_ACTIVE_LOW != 0);
    localparam logic [6:0]            SEG_OFF    = ACT_LOW ? 7'h7F : 7'h00;
    localparam logic [pCNT_WIDTH-1:0] DIG_TERM   = pCNT_WIDTH'(pSCAN_DIV - 1);
    localparam logic [pCNT_WIDTH-1:0] BLANK_TERM = (pBLANK_CYC > 0) ? pCNT_WIDTH'(pBLANK_CYC - 1) : '0;

    scan_state_e           state_q, state_d;
    logic [6:0]            snap_a_q, snap_a_d, snap_b_q, snap_b_d;
    logic [6:0]            seg_q, seg_d, lit_pat_s;
    logic [1:0]            dig_sel_q, dig_sel_d;
    logic                  frame_done_q, frame_done_d;
    logic                  enter_a_s, enter_b_s, clr_s, last_s, blank_digits_s;
    logic [pCNT_WIDTH-1:0] term_s;

    scan_phase_timer #(.pCNT_WIDTH(pCNT_WIDTH)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (clr_s),
        .inc_i  (1'b1),
        .term_i (term_s),
        .last_o (last_s)
    );

    // Next-state logic; dropping en always returns to IDLE.
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    state_d = ST_DIG_A;
                ST_DIG_A:   if (last_s) state_d = (pBLANK_CYC == 0) ? ST_DIG_B : ST_BLANK_A;
                            else        state_d = ST_DIG_A;
                ST_BLANK_A: if (last_s) state_d = ST_DIG_B;
                            else        state_d = ST_BLANK_A;
                ST_DIG_B:   if (last_s) state_d = (pBLANK_CYC == 0) ? ST_DIG_A : ST_BLANK_B;
                            else        state_d = ST_DIG_B;
                ST_BLANK_B: if (last_s) state_d = ST_DIG_A;
                            else        state_d = ST_BLANK_B;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // Timer control: restart on every state entry (and while idle), with
    // the terminal value of the state being entered.
    always_comb begin
        clr_s = (state_d != state_q) || (state_d == ST_IDLE);
        case (state_d)
            ST_DIG_A, ST_DIG_B:     term_s = DIG_TERM;
            ST_BLANK_A, ST_BLANK_B: term_s = BLANK_TERM;
            default:                term_s = '1;
        endcase
    end

`ifdef DISPLAY_BLINK_EN
    localparam int BW = (pBLINK_FRAMES > 1) ? $clog2(pBLINK_FRAMES) : 1;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_phase_q, blink_phase_d;

    // Frame counter toggling the blink phase every pBLINK_FRAMES frames.
    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (state_d == ST_IDLE) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else if (frame_done_d) begin
            if (blink_cnt_q == BW'(pBLINK_FRAMES - 1)) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d   = blink_cnt_q + BW'(1);
            end
        end else begin
            blink_cnt_d   = blink_cnt_q;
        end
        blank_digits_s = blink_req && blink_phase_d;
    end

    // Blink state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end
`else
    assign blank_digits_s = 1'b0;
`endif

    // Snapshot capture and registered output values for the state being entered.
    always_comb begin
        enter_a_s    = (state_d == ST_DIG_A) && (state_q != ST_DIG_A);
        enter_b_s    = (state_d == ST_DIG_B) && (state_q != ST_DIG_B);
        snap_a_d     = enter_a_s ? seg_a : snap_a_q;
        snap_b_d     = enter_b_s ? seg_b : snap_b_q;
        frame_done_d = enter_a_s && ((state_q == ST_BLANK_B) || (state_q == ST_DIG_B));
        if (lamp_test) begin
            lit_pat_s = 7'h7F;
        end else if (state_d == ST_DIG_A) begin
            lit_pat_s = snap_a_d;
        end else begin
            lit_pat_s = snap_b_d;
        end
        case (state_d)
            ST_DIG_A: begin
                dig_sel_d = DIG_SEL_A;
                seg_d     = (blank_digits_s && !lamp_test) ? SEG_OFF : seg_drive(lit_pat_s, ACT_LOW);
            end
            ST_DIG_B: begin
                dig_sel_d = DIG_SEL_B;
                seg_d     = (blank_digits_s && !lamp_test) ? SEG_OFF : seg_drive(lit_pat_s, ACT_LOW);
            end
            default: begin
                dig_sel_d = DIG_SEL_NONE;
                seg_d     = SEG_OFF;
            end
        endcase
    end

    // State, snapshot and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            snap_a_q     <= 7'h00;
            snap_b_q     <= 7'h00;
            seg_q        <= SEG_OFF;
            dig_sel_q    <= DIG_SEL_NONE;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            snap_a_q     <= snap_a_d;
            snap_b_q     <= snap_b_d;
            seg_q        <= seg_d;
            dig_sel_q    <= dig_sel_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg_out    = seg_q;
    assign dig_sel    = dig_sel_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Self-checking bench for display_scan_driver: one instance with a 2-cycle
// blank gap, one with none, both driven by the same directed stimulus and
// compared every cycle against a frame-position model.
module tb_display_scan_driver;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n, en, lamp_test;
    logic [6:0] seg_a, seg_b;
    logic [6:0] seg0, seg1;
    logic [1:0] dig0, dig1;
    logic       fd0, fd1;

    int checks   = 0;
    int failures = 0;

    int         blank_cyc [2] = '{2, 0};
    int         running   [2];
    int         t_pos     [2];
    logic [6:0] msnap_a   [2];
    logic [6:0] msnap_b   [2];
    logic [6:0] eseg      [2];
    logic [1:0] edig      [2];
    logic       efd       [2];

    always #5 clk = ~clk;

    display_scan_driver #(.pSCAN_DIV(D), .pBLANK_CYC(2), .pCNT_WIDTH(8), .pSEG_ACTIVE_LOW(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .lamp_test(lamp_test), .seg_a(seg_a), .seg_b(seg_b),
`ifdef DISPLAY_BLINK_EN
        .blink_req(1'b0),
`endif
        .seg_out(seg0), .dig_sel(dig0), .frame_done(fd0)
    );

    display_scan_driver #(.pSCAN_DIV(D), .pBLANK_CYC(0), .pCNT_WIDTH(8), .pSEG_ACTIVE_LOW(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .lamp_test(lamp_test), .seg_a(seg_a), .seg_b(seg_b),
`ifdef DISPLAY_BLINK_EN
        .blink_req(1'b0),
`endif
        .seg_out(seg1), .dig_sel(dig1), .frame_done(fd1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: outputs follow from the position within the frame since the start.
    task automatic model_update();
        int b, per, p;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n || !en) begin
                running[d] = 0;
                t_pos[d]   = 0;
                eseg[d]    = 7'h7F;
                edig[d]    = 2'b00;
                efd[d]     = 1'b0;
                if (!rst_n) begin
                    msnap_a[d] = 7'h00;
                    msnap_b[d] = 7'h00;
                end
            end else begin
                b   = blank_cyc[d];
                per = 2 * (D + b);
                if (running[d] != 0) begin
                    t_pos[d]++;
                end else begin
                    running[d] = 1;
                    t_pos[d]   = 0;
                end
                p      = t_pos[d] % per;
                efd[d] = (t_pos[d] > 0) && (p == 0);
                if (p == 0)     msnap_a[d] = seg_a;
                if (p == D + b) msnap_b[d] = seg_b;
                if (p < D) begin
                    edig[d] = 2'b01;
                    eseg[d] = lamp_test ? 7'h00 : ~msnap_a[d];
                end else if (p < D + b) begin
                    edig[d] = 2'b00;
                    eseg[d] = 7'h7F;
                end else if (p < 2 * D + b) begin
                    edig[d] = 2'b10;
                    eseg[d] = lamp_test ? 7'h00 : ~msnap_b[d];
                end else begin
                    edig[d] = 2'b00;
                    eseg[d] = 7'h7F;
                end
            end
        end
    endtask

    // One clock: advance the model on the edge, compare #1 later.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        chk("blank2_seg_out",    seg0, eseg[0]);
        chk("blank2_dig_sel",    dig0, edig[0]);
        chk("blank2_frame_done", fd0,  efd[0]);
        chk("noblank_seg_out",   seg1, eseg[1]);
        chk("noblank_dig_sel",   dig1, edig[1]);
        chk("noblank_frame_done", fd1, efd[1]);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; lamp_test = 1'b0; seg_a = 7'h06; seg_b = 7'h5B;
        for (int k = 0; k < 3; k++) step();
        chk("reset_seg_literal", seg0, 7'h7F);
        chk("reset_dig_literal", dig0, 2'b00);

        // Start scanning; change seg_a inside the first DIG_A phase.
        rst_n = 1'b1; en = 1'b1;
        for (int i = 0; i < 26; i++) begin
            if (i == 1) seg_a = 7'h3F;
            step();
            if (i == 0)  begin chk("start_seg_a", seg0, 7'h79); chk("start_dig_a", dig0, 2'b01); end
            if (i == 2)  chk("snapshot_hold", seg0, 7'h79);
            if (i == 4)  begin chk("blank_a_seg", seg0, 7'h7F); chk("blank_a_dig", dig0, 2'b00); end
            if (i == 4)  begin chk("noblank_b_seg", seg1, 7'h24); chk("noblank_b_dig", dig1, 2'b10); end
            if (i == 6)  begin chk("dig_b_seg", seg0, 7'h24); chk("dig_b_dig", dig0, 2'b10); end
            if (i == 8)  chk("noblank_frame_done", fd1, 1'b1);
            if (i == 11) chk("no_early_frame_done", fd0, 1'b0);
            if (i == 12) begin chk("frame_done_12", fd0, 1'b1); chk("new_snapshot", seg0, 7'h40); end
            if (i == 24) chk("frame_done_24", fd0, 1'b1);
        end

        // Move into DIG_B, then drop en.
        for (int k = 0; k < 6; k++) step();
        chk("in_dig_b", dig0, 2'b10);
        en = 1'b0;
        step();
        chk("stop_seg", seg0, 7'h7F);
        chk("stop_dig", dig0, 2'b00);
        chk("stop_no_fd", fd0, 1'b0);
        en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("restart_dig", dig0, (k < 4) ? 2'b01 : 2'b00);
        end

        // Reset in the middle of BLANK_A, then resume.
        rst_n = 1'b0;
        step();
        chk("midreset_seg", seg0, 7'h7F);
        chk("midreset_dig", dig0, 2'b00);
        rst_n = 1'b1;
        step();
        chk("after_reset_seg", seg0, 7'h40);
        chk("after_reset_dig", dig0, 2'b01);

        // Lamp test across a full frame.
        lamp_test = 1'b1;
        for (int j = 0; j < 14; j++) begin
            step();
            if (j == 0) chk("lamp_dig_a", seg0, 7'h00);
            if (j == 3) chk("lamp_blank", seg0, 7'h7F);
            if (j == 5) begin chk("lamp_dig_b", seg0, 7'h00); chk("lamp_dig_b_sel", dig0, 2'b10); end
        end
        lamp_test = 1'b0;
        seg_b = 7'h66;
        for (int k = 0; k < 12; k++) step();
        en = 1'b0;
        for (int k = 0; k < 3; k++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
